// File: rtl/contador_pkg.sv
// Shared types and the +/-1 step helper for the programmable counter.
package contador_pkg;

  typedef enum logic [1:0] {IDLE, CONTANDO, FIN} estado_t;

  // Widest counter the step helper supports; callers cast in and out.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] siguiente_cuenta(input logic [MAX_W-1:0] valor,
                                                        input logic             subir);
    return subir ? valor + MAX_W'(1) : valor - MAX_W'(1);
  endfunction

endpackage

// File: rtl/contador_programable_if.sv
// Command/status bundle of the programmable counter: master drives commands, slave is the counter.
interface contador_programable_if #(parameter int N = 4);

  logic [N-1:0] carga;
  logic         cargar;
  logic         iniciar;
  logic         detener;
  logic         habilitar;
  logic         modo_subir;
  logic         modo_ciclo;
  logic [N-1:0] cuenta;
  logic         fin;
  logic         ocupado;
  logic         terminado;

  modport master (
    output carga, cargar, iniciar, detener, habilitar, modo_subir, modo_ciclo,
    input  cuenta, fin, ocupado, terminado
  );

  modport slave (
    input  carga, cargar, iniciar, detener, habilitar, modo_subir, modo_ciclo,
    output cuenta, fin, ocupado, terminado
  );

endinterface

// File: rtl/divisor_tick.sv
// Prescaler: emits a one-cycle tick every PRESC enabled cycles; freezes while habilitar is low.
module divisor_tick #(
  parameter int PRESC = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic habilitar,
  output logic tick
);

  localparam int W = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [W-1:0] cnt;

  assign tick = habilitar && (cnt == W'(PRESC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (habilitar) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/contador_programable.sv
// Programmable up/down counter with single-shot or cyclic mode, prescaled step and terminal pulse.
module contador_programable
  import contador_pkg::*;
#(
  parameter int N     = 4,
  parameter int PRESC = 1
) (
  input logic                   clock,
  input logic                   reset,
  contador_programable_if.slave bus
);

  estado_t      estado, estado_n;
  logic [N-1:0] cuenta, cuenta_n;
  logic [N-1:0] limite, limite_n;
  logic         subir, subir_n;
  logic         ciclo, ciclo_n;
  logic         fin, fin_n;
  logic         clear;
  logic         tick;

  logic [N-1:0] inicio, terminal, paso;
  logic [N-1:0] inicio_nuevo, terminal_nuevo;

  // Start/terminal from the latched configuration and from the live inputs (for iniciar).
  assign inicio         = subir ? '0 : limite;
  assign terminal       = subir ? limite : '0;
  assign inicio_nuevo   = bus.modo_subir ? '0 : bus.carga;
  assign terminal_nuevo = bus.modo_subir ? bus.carga : '0;
  assign paso           = N'(siguiente_cuenta(MAX_W'(cuenta), subir));

  divisor_tick #(.PRESC(PRESC)) u_divisor (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .habilitar (bus.habilitar && (estado == CONTANDO)),
    .tick      (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= IDLE;
      cuenta <= '0;
      limite <= '0;
      subir  <= 1'b0;
      ciclo  <= 1'b0;
      fin    <= 1'b0;
    end else begin
      estado <= estado_n;
      cuenta <= cuenta_n;
      limite <= limite_n;
      subir  <= subir_n;
      ciclo  <= ciclo_n;
      fin    <= fin_n;
    end
  end

  always_comb begin
    estado_n = estado;
    cuenta_n = cuenta;
    limite_n = limite;
    subir_n  = subir;
    ciclo_n  = ciclo;
    fin_n    = 1'b0;
    clear    = 1'b0;
    if (bus.detener) begin
      estado_n = IDLE;
      clear    = 1'b1;
    end else if (bus.iniciar) begin
      limite_n = bus.carga;
      subir_n  = bus.modo_subir;
      ciclo_n  = bus.modo_ciclo;
      cuenta_n = inicio_nuevo;
      clear    = 1'b1;
      if (inicio_nuevo == terminal_nuevo) begin
        fin_n    = 1'b1;
        estado_n = bus.modo_ciclo ? CONTANDO : FIN;
      end else begin
        estado_n = CONTANDO;
      end
    end else if (bus.cargar && (estado != CONTANDO)) begin
      cuenta_n = bus.carga;
      estado_n = IDLE;
    end else if ((estado == CONTANDO) && tick) begin
      if (cuenta != terminal) begin
        cuenta_n = paso;
        if (paso == terminal) begin
          fin_n = 1'b1;
          if (!ciclo) estado_n = FIN;
        end
      end else begin
        // Only reachable in cyclic mode: reload, and re-pulse when start already is terminal.
        cuenta_n = inicio;
        fin_n    = (inicio == terminal);
      end
    end
  end

  assign bus.cuenta    = cuenta;
  assign bus.fin       = fin;
  assign bus.ocupado   = (estado == CONTANDO);
  assign bus.terminado = (estado == FIN);

endmodule

// File: tb/tb_contador_programable.sv
// Scoreboard bench: two counters (PRESC=1 and PRESC=3) driven with directed vectors.
module tb_contador_programable;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  contador_programable_if #(.N(4)) bus1 ();
  contador_programable_if #(.N(4)) bus3 ();

  contador_programable #(.N(4), .PRESC(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  contador_programable #(.N(4), .PRESC(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  typedef struct {
    int         ciclo;
    logic [3:0] cuenta;
    logic       fin;
    logic       ocupado;
    logic       terminado;
    string      nombre;
  } esperado_t;

  esperado_t cola1[$];
  esperado_t cola3[$];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic comparar(string nm, int at, logic [6:0] got, logic [6:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d: got cuenta=%0d fin=%b ocupado=%b terminado=%b, expected cuenta=%0d fin=%b ocupado=%b terminado=%b",
               nm, at, got[6:3], got[2], got[1], got[0], req[6:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic esperar1(int off, logic [3:0] c, logic f, logic o, logic t, string nm);
    esperado_t e;
    e.ciclo = cyc + off; e.cuenta = c; e.fin = f; e.ocupado = o; e.terminado = t; e.nombre = nm;
    cola1.push_back(e);
  endtask

  task automatic esperar3(int off, logic [3:0] c, logic f, logic o, logic t, string nm);
    esperado_t e;
    e.ciclo = cyc + off; e.cuenta = c; e.fin = f; e.ocupado = o; e.terminado = t; e.nombre = nm;
    cola3.push_back(e);
  endtask

  task automatic paso(int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitors: pop every expectation that falls due on this cycle.
  always @(negedge clock) begin
    esperado_t e;
    while (cola1.size() > 0 && cola1[0].ciclo <= cyc) begin
      e = cola1.pop_front();
      if (e.ciclo < cyc) begin
        tests++; fails++;
        $display("FAIL %s: check due at cyc=%0d missed, now %0d", e.nombre, e.ciclo, cyc);
      end else begin
        comparar(e.nombre, cyc, {bus1.cuenta, bus1.fin, bus1.ocupado, bus1.terminado},
                 {e.cuenta, e.fin, e.ocupado, e.terminado});
      end
    end
  end

  always @(negedge clock) begin
    esperado_t e;
    while (cola3.size() > 0 && cola3[0].ciclo <= cyc) begin
      e = cola3.pop_front();
      if (e.ciclo < cyc) begin
        tests++; fails++;
        $display("FAIL %s: check due at cyc=%0d missed, now %0d", e.nombre, e.ciclo, cyc);
      end else begin
        comparar(e.nombre, cyc, {bus3.cuenta, bus3.fin, bus3.ocupado, bus3.terminado},
                 {e.cuenta, e.fin, e.ocupado, e.terminado});
      end
    end
  end

  initial begin
    bus1.carga = '0; bus1.cargar = 0; bus1.iniciar = 0; bus1.detener = 0;
    bus1.habilitar = 1; bus1.modo_subir = 0; bus1.modo_ciclo = 0;
    bus3.carga = '0; bus3.cargar = 0; bus3.iniciar = 0; bus3.detener = 0;
    bus3.habilitar = 1; bus3.modo_subir = 0; bus3.modo_ciclo = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    comparar("reset_dut1", cyc, {bus1.cuenta, bus1.fin, bus1.ocupado, bus1.terminado}, 7'b0);
    comparar("reset_dut3", cyc, {bus3.cuenta, bus3.fin, bus3.ocupado, bus3.terminado}, 7'b0);
    @(negedge clock);
    reset = 1'b1;
    paso(1);

    // 1: down 5..0 single-shot
    bus1.carga = 4'd5; bus1.modo_subir = 0; bus1.modo_ciclo = 0; bus1.iniciar = 1;
    for (int i = 1; i <= 6; i++) esperar1(i, 4'(6 - i), i == 6, i < 6, i == 6, "t1_bajada");
    esperar1(7, 4'd0, 0, 0, 1, "t1_retiene");
    esperar1(8, 4'd0, 0, 0, 1, "t1_retiene");
    paso(1); bus1.iniciar = 0; paso(7);

    // 2: up 0..3 cyclic, then abort holds cuenta
    bus1.carga = 4'd3; bus1.modo_subir = 1; bus1.modo_ciclo = 1; bus1.iniciar = 1;
    for (int i = 1; i <= 10; i++) esperar1(i, 4'((i - 1) % 4), ((i - 1) % 4) == 3, 1, 0, "t2_ciclo");
    paso(1); bus1.iniciar = 0; paso(9);
    bus1.detener = 1;
    esperar1(1, 4'd1, 0, 0, 0, "t2_detener");
    esperar1(2, 4'd1, 0, 0, 0, "t2_detener_retiene");
    paso(1); bus1.detener = 0; paso(2);

    // 3: PRESC=3 down from 2 with two disabled cycles
    bus3.carga = 4'd2; bus3.modo_subir = 0; bus3.modo_ciclo = 0; bus3.iniciar = 1;
    for (int i = 1; i <= 3; i++) esperar3(i, 4'd2, 0, 1, 0, "t3_presc");
    for (int i = 4; i <= 8; i++) esperar3(i, 4'd1, 0, 1, 0, "t3_presc_pausa");
    esperar3(9, 4'd0, 1, 0, 1, "t3_fin");
    esperar3(10, 4'd0, 0, 0, 1, "t3_fin_pulso");
    paso(1); bus3.iniciar = 0; paso(3);
    bus3.habilitar = 0; paso(2);
    bus3.habilitar = 1; paso(4);

    // 4a: carga=0 single-shot goes straight to FIN with one pulse
    bus1.carga = 4'd0; bus1.modo_subir = 0; bus1.modo_ciclo = 0; bus1.iniciar = 1;
    esperar1(1, 4'd0, 1, 0, 1, "t4_carga0");
    esperar1(2, 4'd0, 0, 0, 1, "t4_carga0_pulso");
    paso(1); bus1.iniciar = 0; paso(2);

    // 4b: up to 15 without wrapping
    bus1.carga = 4'd15; bus1.modo_subir = 1; bus1.modo_ciclo = 0; bus1.iniciar = 1;
    for (int i = 1; i <= 16; i++) esperar1(i, 4'(i - 1), i == 16, i < 16, i == 16, "t4_max");
    esperar1(17, 4'd15, 0, 0, 1, "t4_sin_desborde");
    paso(1); bus1.iniciar = 0; paso(17);

    // 6: cargar and mode change ignored while counting; cargar in FIN reloads into IDLE
    bus1.carga = 4'd4; bus1.modo_subir = 0; bus1.modo_ciclo = 0; bus1.iniciar = 1;
    for (int i = 1; i <= 5; i++) esperar1(i, 4'(5 - i), i == 5, i < 5, i == 5, "t6_ignora");
    paso(1); bus1.iniciar = 0; bus1.cargar = 1; bus1.carga = 4'd9; bus1.modo_subir = 1;
    paso(1); bus1.cargar = 0; paso(3);
    bus1.cargar = 1;
    esperar1(1, 4'd9, 0, 0, 0, "t6_cargar_fin");
    paso(1); bus1.cargar = 0; bus1.modo_subir = 0; paso(1);

    // 5b: detener beats iniciar
    bus1.carga = 4'd6; bus1.modo_subir = 0; bus1.modo_ciclo = 0; bus1.iniciar = 1;
    for (int i = 1; i <= 3; i++) esperar1(i, 4'(7 - i), 0, 1, 0, "t5_bajada");
    paso(1); bus1.iniciar = 0; paso(2);
    bus1.detener = 1; bus1.iniciar = 1; bus1.carga = 4'd9;
    esperar1(1, 4'd4, 0, 0, 0, "t5_detener_prioridad");
    paso(1); bus1.detener = 0; bus1.iniciar = 0; paso(1);

    // 5a: asynchronous reset mid-count at 7
    bus1.carga = 4'd10; bus1.modo_subir = 0; bus1.modo_ciclo = 0; bus1.iniciar = 1;
    for (int i = 1; i <= 4; i++) esperar1(i, 4'(11 - i), 0, 1, 0, "t5_antes_reset");
    paso(1); bus1.iniciar = 0; paso(3);
    #2 reset = 1'b0;
    #1 comparar("t5_reset_async", cyc, {bus1.cuenta, bus1.fin, bus1.ocupado, bus1.terminado}, 7'b0);
    esperar1(1, 4'd0, 0, 0, 0, "t5_en_reset");
    esperar1(2, 4'd0, 0, 0, 0, "t5_tras_reset");
    esperar1(3, 4'd0, 0, 0, 0, "t5_idle");
    paso(1); reset = 1'b1; paso(4);

    if (cola1.size() != 0 || cola3.size() != 0) begin
      tests++; fails++;
      $display("FAIL drenaje: %0d/%0d expectations left, required 0", cola1.size(), cola3.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
